mc_controller: RTL and testbench

- Multicycle control unit for the 32-bit MIPS-subset processor.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Drives every datapath enable and every mux select, including the 2-bit selects of the 4-input muxes (ALU operand B, next-PC source).
- Sits directly upstream of those muxes; consumes opcode/funct from the instruction register and the ALU zero flag.

---
 rtl/mc_pkg.sv | 55 +++++
 rtl/aludec.sv | 30 +++
 rtl/mc_controller.sv | 133 +++++++++++++
 tb/tb_mc_controller.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: states, opcodes,
// funct codes, ALU op classes, ALU control codes and datapath mux selects.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } statetype_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps the controller's ALU op class plus funct to an ALU control code.
// Purely combinational, zero latency; no flow control.
module aludec
    import mc_pkg::*;
(
    input  aluop_t      aluop,
    input  logic [5:0]  funct,
    output logic [2:0]  alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default:   alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset control unit: Moore FSM driving every datapath enable and mux select.
// Outputs follow the registered state; only pcen also sees zero combinationally. No flow control.
module mc_controller
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        pcen,
    output logic        iord,
    output logic        memwrite,
    output logic        irwrite,
    output logic        regdst,
    output logic        memtoreg,
    output logic        regwrite,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  pcsrc,
    output logic [2:0]  alucontrol
);

    statetype_t state_q, state_d;
    statetype_t cur_state;
    aluop_t     aluop;
    logic       pcwrite;
    logic       branch;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // During reset the outputs present FETCH values, minus every write enable.
    assign cur_state = reset ? S_FETCH : state_q;

    always_comb begin
        state_d  = S_FETCH;
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = SRCB_REG;
        pcsrc    = PCSRC_ALU;
        aluop    = ALUOP_ADD;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        case (cur_state)
            S_FETCH: begin
                irwrite = 1'b1;
                alusrcb = SRCB_FOUR;
                pcwrite = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = SRCB_IMMSH;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = PCSRC_ALUOUT;
                branch  = 1'b1;
            end
            S_ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
            end
            S_JUMP: begin
                pcsrc   = PCSRC_JUMP;
                pcwrite = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        if (reset) begin
            irwrite  = 1'b0;
            memwrite = 1'b0;
            regwrite = 1'b0;
            pcwrite  = 1'b0;
            branch   = 1'b0;
        end
    end

    assign pcen = pcwrite | (branch & zero);

    aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Directed vector bench for mc_controller: per-cycle inputs with hand-derived expected outputs.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcen       (pcen),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol)
    );

    // Packed output order: pcen iord memwrite irwrite regdst memtoreg regwrite alusrca alusrcb[2] pcsrc[2] alucontrol[3]
    localparam logic [14:0] E_RST = {8'b0000_0000, 2'b01, 2'b00, 3'b010};
    localparam logic [14:0] E_F   = {8'b1001_0000, 2'b01, 2'b00, 3'b010};
    localparam logic [14:0] E_D   = {8'b0000_0000, 2'b11, 2'b00, 3'b010};
    localparam logic [14:0] E_MA  = {8'b0000_0001, 2'b10, 2'b00, 3'b010};
    localparam logic [14:0] E_MR  = {8'b0100_0000, 2'b00, 2'b00, 3'b010};
    localparam logic [14:0] E_MWB = {8'b0000_0110, 2'b00, 2'b00, 3'b010};
    localparam logic [14:0] E_MW  = {8'b0110_0000, 2'b00, 2'b00, 3'b010};
    localparam logic [14:0] E_AWB = {8'b0000_1010, 2'b00, 2'b00, 3'b010};
    localparam logic [14:0] E_AE  = {8'b0000_0001, 2'b10, 2'b00, 3'b010};
    localparam logic [14:0] E_AW  = {8'b0000_0010, 2'b00, 2'b00, 3'b010};
    localparam logic [14:0] E_J   = {8'b1000_0000, 2'b00, 2'b10, 3'b010};

    function automatic logic [14:0] e_ex(input logic [2:0] alu);
        return {8'b0000_0001, 2'b00, 2'b00, alu};
    endfunction

    function automatic logic [14:0] e_br(input logic z);
        return {z, 7'b000_0001, 2'b00, 2'b01, 3'b110};
    endfunction

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs [0:79];
    int   nvec = 0;
    int   tests = 0;
    int   fails = 0;

    task automatic add(input logic r, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic [14:0] e);
        vecs[nvec] = '{rst: r, op: o, fn: f, z: z, exp: e};
        nvec++;
    endtask

    // Drive one cycle's inputs, compare at the falling edge, then advance past the rising edge.
    task automatic step(input string name, input logic r, input logic [5:0] o,
                        input logic [5:0] f, input logic z, input logic [14:0] e);
        logic [14:0] act;
        reset = r; op = o; funct = f; zero = z;
        @(negedge clk);
        act = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
               alusrcb, pcsrc, alucontrol};
        tests++;
        if (act !== e) begin
            fails++;
            $display("FAIL %s: outputs got %b, expected %b", name, act, e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b0;

        add(1, 6'b100011, 6'b0, 0, E_RST);
        add(1, 6'b100011, 6'b0, 1, E_RST);
        // lw: 5 cycles, zero held high outside BRANCH must not move pcen
        add(0, 6'b100011, 6'b0, 0, E_F);
        add(0, 6'b100011, 6'b0, 0, E_D);
        add(0, 6'b100011, 6'b0, 1, E_MA);
        add(0, 6'b100011, 6'b0, 1, E_MR);
        add(0, 6'b100011, 6'b0, 0, E_MWB);
        // sw
        add(0, 6'b101011, 6'b0, 0, E_F);
        add(0, 6'b101011, 6'b0, 0, E_D);
        add(0, 6'b101011, 6'b0, 0, E_MA);
        add(0, 6'b101011, 6'b0, 0, E_MW);
        // R-type slt, add, sub, and, or, unknown funct
        add(0, 6'b000000, 6'b101010, 0, E_F);
        add(0, 6'b000000, 6'b101010, 0, E_D);
        add(0, 6'b000000, 6'b101010, 0, e_ex(3'b111));
        add(0, 6'b000000, 6'b101010, 0, E_AWB);
        add(0, 6'b000000, 6'b100010, 0, E_F);
        add(0, 6'b000000, 6'b100010, 0, E_D);
        add(0, 6'b000000, 6'b100010, 0, e_ex(3'b110));
        add(0, 6'b000000, 6'b100010, 0, E_AWB);
        add(0, 6'b000000, 6'b100100, 0, E_F);
        add(0, 6'b000000, 6'b100100, 0, E_D);
        add(0, 6'b000000, 6'b100100, 0, e_ex(3'b000));
        add(0, 6'b000000, 6'b100100, 0, E_AWB);
        add(0, 6'b000000, 6'b100101, 0, E_F);
        add(0, 6'b000000, 6'b100101, 0, E_D);
        add(0, 6'b000000, 6'b100101, 0, e_ex(3'b001));
        add(0, 6'b000000, 6'b100101, 0, E_AWB);
        add(0, 6'b000000, 6'b100000, 0, E_F);
        add(0, 6'b000000, 6'b100000, 0, E_D);
        add(0, 6'b000000, 6'b100000, 0, e_ex(3'b010));
        add(0, 6'b000000, 6'b100000, 0, E_AWB);
        add(0, 6'b000000, 6'b111111, 0, E_F);
        add(0, 6'b000000, 6'b111111, 0, E_D);
        add(0, 6'b000000, 6'b111111, 0, e_ex(3'b010));
        add(0, 6'b000000, 6'b111111, 0, E_AWB);
        // beq taken / not taken
        add(0, 6'b000100, 6'b0, 1, E_F);
        add(0, 6'b000100, 6'b0, 1, E_D);
        add(0, 6'b000100, 6'b0, 1, e_br(1'b1));
        add(0, 6'b000100, 6'b0, 0, E_F);
        add(0, 6'b000100, 6'b0, 0, E_D);
        add(0, 6'b000100, 6'b0, 0, e_br(1'b0));
        // j
        add(0, 6'b000010, 6'b0, 0, E_F);
        add(0, 6'b000010, 6'b0, 0, E_D);
        add(0, 6'b000010, 6'b0, 0, E_J);
        // unknown op: 2 cycles, no write enable
        add(0, 6'b111111, 6'b0, 1, E_F);
        add(0, 6'b111111, 6'b0, 1, E_D);
        // addi
        add(0, 6'b001000, 6'b0, 0, E_F);
        add(0, 6'b001000, 6'b0, 0, E_D);
        add(0, 6'b001000, 6'b0, 0, E_AE);
        add(0, 6'b001000, 6'b0, 0, E_AW);
        add(0, 6'b001000, 6'b0, 0, E_F);

        @(posedge clk);
        #1;
        for (int i = 0; i < nvec; i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].op, vecs[i].fn,
                 vecs[i].z, vecs[i].exp);
        end

        // Reset hits a lw in MEMRD: aborted, FETCH afterwards.
        step("abort_rd_dec", 0, 6'b100011, 6'b0, 0, E_D);
        step("abort_rd_ma",  0, 6'b100011, 6'b0, 0, E_MA);
        step("abort_rd_rst", 1, 6'b100011, 6'b0, 1, E_RST);
        step("abort_rd_f",   0, 6'b100011, 6'b0, 0, E_F);
        step("abort_rd_d",   0, 6'b100011, 6'b0, 0, E_D);

        // Reset hits a lw in MEMWB: the regwrite pulse is suppressed.
        step("abort_wb_ma",  0, 6'b100011, 6'b0, 0, E_MA);
        step("abort_wb_mr",  0, 6'b100011, 6'b0, 0, E_MR);
        step("abort_wb_rst", 1, 6'b100011, 6'b0, 0, E_RST);
        step("abort_wb_f",   0, 6'b101011, 6'b0, 0, E_F);

        // Reset hits a jump and a sw write cycle.
        step("abort_j_d",    0, 6'b000010, 6'b0, 0, E_D);
        step("abort_j_rst",  1, 6'b000010, 6'b0, 0, E_RST);
        step("abort_sw_f",   0, 6'b101011, 6'b0, 0, E_F);
        step("abort_sw_d",   0, 6'b101011, 6'b0, 0, E_D);
        step("abort_sw_ma",  0, 6'b101011, 6'b0, 0, E_MA);
        step("abort_sw_rst", 1, 6'b101011, 6'b0, 0, E_RST);
        step("abort_sw_f2",  0, 6'b101011, 6'b0, 0, E_F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
